payload_aligner_stream: RTL and testbench
=========================================

# payload_aligner_stream

Parametrised header stripper and payload aligner for the packet_dissector datapath. It sits between the ingress byte stream and the downstream payload consumers. It captures a run-time-selectable number of leading header bytes into a wide header register. The remaining payload is re-packed so its first byte lands in byte lane 0, with valid/ready backpressure on both sides.

## Interface
- DATA_BYTES, 8: bus width in bytes; power of two, 2..64.
- MAX_HDR_BYTES, 32: capacity of the header register in bytes.
- HDR_LEN_W, $clog2(MAX_HDR_BYTES+1): width of hdr_len.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  DATA_BYTES*8  byte i at bits [(i+1)*8-1 -: 8].
- in_byte_enable  in  DATA_BYTES  all ones except on the eop beat, which is contiguous from bit 0 and nonzero.
- in_sop  in  1  first beat of packet.
- in_eop  in  1  last beat of packet.
- hdr_len  in  HDR_LEN_W  header length in bytes; sampled on the accepted sop beat; values above MAX_HDR_BYTES are clamped.
- headers  out  MAX_HDR_BYTES*8  header byte i at [(i+1)*8-1 -: 8]; bytes ≥ hdr_len are zero.
- headers_valid  out  1  one-cycle pulse when headers is updated.
- payload_valid  out  1  output beat valid.
- payload_ready  in  1  downstream accepts the beat.
- payload  out  DATA_BYTES*8  aligned payload bytes, same lane mapping as in_data.
- byte_enable  out  DATA_BYTES  all ones except on the eop beat, which is contiguous from bit 0.
- sop  out  1  first payload beat.
- eop  out  1  last payload beat.
- err_short  out  1  one-cycle pulse when a packet ends before hdr_len bytes have arrived.

## Operation
- States: IDLE, HDR, PAY, FLUSH.
- IDLE
  - Accepted beats without in_sop are discarded.
  - A sop beat latches L = min(hdr_len, MAX_HDR_BYTES), clears headers, and is then handled as in HDR.
- HDR
  - Header bytes are written at byte offset hdr_cnt; hdr_cnt increments by the bytes consumed.
  - When hdr_cnt reaches L, the remaining bytes of that beat go to the residual register, and the state moves to PAY.
  - L = 0 completes the header on the sop beat with zero bytes consumed.
- Residual register
  - Holds up to DATA_BYTES-1 bytes, count res_cnt, with shift = L mod DATA_BYTES.
  - Each output beat is the residual bytes in the low lanes, followed by the new input bytes.
  - Overflow input bytes become the new residual.
- eop handling
  - When an eop beat is accepted and the remaining bytes (res_cnt plus new bytes) are ≤ DATA_BYTES, they go out as one eop beat, and the state returns to IDLE.
  - When they exceed DATA_BYTES, a full beat is emitted, the state moves to FLUSH, and the final residual goes out as the eop beat.
- Zero-length payload
  - Occurs when eop coincides with exact header completion.
  - headers_valid pulses; no payload beat is emitted; the state returns to IDLE.
- Short packet
  - Occurs when eop is accepted in HDR with hdr_cnt < L.
  - err_short pulses; headers_valid is not asserted; headers keeps its previous value; the state returns to IDLE.
- in_sop while in HDR, PAY or FLUSH: the old packet is abandoned without eop, and the new packet starts.
- headers holds its value from the headers_valid pulse until the next pulse.
- sop is set on the first emitted payload beat of each packet only.

## Timing
- Reset: all outputs 0; in_ready = 1 the cycle after rst deasserts; state IDLE; counters and residual cleared.
- A reset mid-packet drops all in-flight data, with no eop emitted.
- All outputs are registered.
  - headers_valid is asserted the cycle after the header-completing beat is accepted.
  - A payload beat appears the cycle after the input beat that completes it is accepted.
- in_ready = (!payload_valid || payload_ready) && state != FLUSH.
  - This holds in every state, so throughput is one beat per cycle with no bubbles, except for a single FLUSH cycle when an eop beat overflows.
- While payload_valid && !payload_ready: payload, byte_enable, sop and eop are held stable.
- payload_valid stays high until the beat is accepted.

## Test plan
- Basic unaligned case
  - Stimulus: DATA_BYTES=8, hdr_len=20, 40-byte packet 0x00..0x27, payload_ready=1.
  - Response: headers bytes 0..19 = 0x00..0x13, higher bytes 0; headers_valid pulses the cycle after the 3rd beat.
  - Payload beats: 0x14..0x1B (sop), 0x1C..0x23, then 0x24..0x27 with byte_enable 0x0F and eop. in_ready is low for exactly one FLUSH cycle.
- Aligned header: hdr_len=16, 32-byte packet → 2 full payload beats, sop then eop, byte_enable 0xFF; in_ready never drops.
- Zero-length header: hdr_len=0, 13-byte packet → headers_valid with headers=0; payload equals the input, last beat byte_enable 0x1F.
- Short packet: hdr_len=20, 12-byte packet → err_short pulses once; no headers_valid, no payload; the next 40-byte packet behaves as in the basic case.
- Backpressure: the basic case with payload_ready toggling 1,0,1,0… → identical payload; outputs stable while stalled; no dropped or duplicated beats.
- Reset mid-packet: rst for one cycle during PAY → all outputs 0 next cycle, no eop emitted; the following packet is correct.

Source files
------------

// File: rtl/payload_aligner_stream.sv
// Header stripper and payload aligner: captures the leading hdr_len bytes of
// each packet into a wide header register and re-packs the remaining payload
// so its first byte lands in byte lane 0, with valid/ready on both sides.
module payload_aligner_stream #(
  parameter int DATA_BYTES    = 8,
  parameter int MAX_HDR_BYTES = 32,
  parameter int HDR_LEN_W     = $clog2(MAX_HDR_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_BYTES*8-1:0]    in_data,
  input  logic [DATA_BYTES-1:0]      in_byte_enable,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic [HDR_LEN_W-1:0]       hdr_len,
  output logic [MAX_HDR_BYTES*8-1:0] headers,
  output logic                       headers_valid,
  output logic                       payload_valid,
  input  logic                       payload_ready,
  output logic [DATA_BYTES*8-1:0]    payload,
  output logic [DATA_BYTES-1:0]      byte_enable,
  output logic                       sop,
  output logic                       eop,
  output logic                       err_short
);
  localparam int DW    = DATA_BYTES * 8;
  localparam int HW    = MAX_HDR_BYTES * 8;
  localparam int RES_W = $clog2(DATA_BYTES);

  typedef enum logic [1:0] {IDLE, HDR, PAY, FLUSH} state_t;

  state_t               state;
  logic [HDR_LEN_W-1:0] hdr_len_q;      // clamped header length of the current packet
  logic [HDR_LEN_W-1:0] hdr_cnt;        // header bytes captured so far
  logic [HW-1:0]        hdr_acc;        // header under construction
  logic [DW-1:0]        res_data;       // leftover payload bytes, lane 0 first
  logic [RES_W-1:0]     res_cnt;
  logic                 first_pending;  // next emitted beat is the packet's first

  // Contiguous lane mask with the low n lanes set.
  function automatic logic [DATA_BYTES-1:0] lane_mask(input int n);
    logic [DATA_BYTES-1:0] m;
    for (int i = 0; i < DATA_BYTES; i++) m[i] = (i < n);
    return m;
  endfunction

  logic                 in_fire;
  logic                 in_hdr;
  logic                 hdr_done;
  logic                 first_eff;
  logic [HDR_LEN_W-1:0] hdr_len_clamped;
  int                   l_eff;
  int                   cnt_eff;
  int                   res_cnt_eff;
  int                   beat_bytes;
  int                   consume;
  int                   rem_bytes;
  int                   total;
  logic [DW-1:0]        data_m;
  logic [DW-1:0]        hdr_bytes;
  logic [DW-1:0]        rem_data;
  logic [DW-1:0]        res_eff;
  logic [HW-1:0]        acc_eff;
  logic [HW-1:0]        acc_next;
  logic [2*DW-1:0]      comb_buf;

  assign in_ready = !rst && (!payload_valid || payload_ready) && (state != FLUSH);
  assign in_fire  = in_valid && in_ready;
  assign hdr_len_clamped = (hdr_len > HDR_LEN_W'(MAX_HDR_BYTES)) ? HDR_LEN_W'(MAX_HDR_BYTES) : hdr_len;

  // Split the accepted beat into header bytes and payload bytes, and merge the
  // payload bytes behind the residual.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred;
    // blocking assignments are correct here because this is combinational.
    in_hdr      = in_sop || (state == HDR);
    l_eff       = in_sop ? int'(hdr_len_clamped) : int'(hdr_len_q);
    cnt_eff     = in_sop ? 0 : int'(hdr_cnt);
    acc_eff     = in_sop ? '0 : hdr_acc;
    res_eff     = in_sop ? '0 : res_data;
    res_cnt_eff = in_sop ? 0 : int'(res_cnt);
    first_eff   = in_hdr || first_pending;
    beat_bytes  = 0;
    data_m      = '0;
    hdr_bytes   = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (in_byte_enable[i]) beat_bytes = beat_bytes + 1;
      data_m[i*8 +: 8] = in_byte_enable[i] ? in_data[i*8 +: 8] : 8'h00;
    end
    consume = 0;
    if (in_hdr) consume = (l_eff - cnt_eff < beat_bytes) ? (l_eff - cnt_eff) : beat_bytes;
    for (int i = 0; i < DATA_BYTES; i++)
      hdr_bytes[i*8 +: 8] = (i < consume) ? data_m[i*8 +: 8] : 8'h00;
    hdr_done  = in_hdr && (cnt_eff + consume == l_eff);
    acc_next  = acc_eff | HW'({{HW{1'b0}}, hdr_bytes} << (cnt_eff * 8));
    rem_data  = data_m >> (consume * 8);
    rem_bytes = beat_bytes - consume;
    comb_buf  = {{DW{1'b0}}, res_eff} | ({{DW{1'b0}}, rem_data} << (res_cnt_eff * 8));
    total     = res_cnt_eff + rem_bytes;
  end

  // Packet FSM together with header capture, residual and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state         <= IDLE;
      hdr_len_q     <= '0;
      hdr_cnt       <= '0;
      hdr_acc       <= '0;
      res_data      <= '0;
      res_cnt       <= '0;
      first_pending <= 1'b0;
      headers       <= '0;
      headers_valid <= 1'b0;
      payload_valid <= 1'b0;
      payload       <= '0;
      byte_enable   <= '0;
      sop           <= 1'b0;
      eop           <= 1'b0;
      err_short     <= 1'b0;
    end else begin
      headers_valid <= 1'b0;
      err_short     <= 1'b0;
      if (payload_valid && payload_ready) payload_valid <= 1'b0;

      if (state == FLUSH) begin
        // Overflowed eop: send the final residual once the full beat drains.
        if (payload_valid && payload_ready) begin
          payload_valid <= 1'b1;
          payload       <= res_data;
          byte_enable   <= lane_mask(int'(res_cnt));
          sop           <= 1'b0;
          eop           <= 1'b1;
          res_data      <= '0;
          res_cnt       <= '0;
          state         <= IDLE;
        end
      end else if (in_fire && (in_sop || state != IDLE)) begin
        hdr_len_q <= HDR_LEN_W'(l_eff);
        if (in_hdr && !hdr_done) begin
          res_data      <= '0;
          res_cnt       <= '0;
          first_pending <= 1'b1;
          if (in_eop) begin
            err_short <= 1'b1;
            state     <= IDLE;
          end else begin
            hdr_cnt <= HDR_LEN_W'(cnt_eff + consume);
            hdr_acc <= acc_next;
            state   <= HDR;
          end
        end else begin
          if (hdr_done) begin
            hdr_cnt       <= HDR_LEN_W'(l_eff);
            hdr_acc       <= acc_next;
            headers       <= acc_next;
            headers_valid <= 1'b1;
          end
          if (in_eop && total == 0) begin
            res_cnt <= '0;
            state   <= IDLE;
          end else if (in_eop && total <= DATA_BYTES) begin
            payload_valid <= 1'b1;
            payload       <= comb_buf[DW-1:0];
            byte_enable   <= lane_mask(total);
            sop           <= first_eff;
            eop           <= 1'b1;
            first_pending <= 1'b0;
            res_data      <= '0;
            res_cnt       <= '0;
            state         <= IDLE;
          end else if (total >= DATA_BYTES) begin
            payload_valid <= 1'b1;
            payload       <= comb_buf[DW-1:0];
            byte_enable   <= '1;
            sop           <= first_eff;
            eop           <= 1'b0;
            first_pending <= 1'b0;
            res_data      <= comb_buf[2*DW-1:DW];
            res_cnt       <= RES_W'(total - DATA_BYTES);
            state         <= in_eop ? FLUSH : PAY;
          end else begin
            res_data      <= comb_buf[DW-1:0];
            res_cnt       <= RES_W'(total);
            first_pending <= first_eff;
            state         <= PAY;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_payload_aligner_stream.sv
// Self-checking bench for payload_aligner_stream: table of packet scenarios
// plus hand-written reset, discard and abandon sequences, with a scoreboard
// of expected header and payload beats filled from a byte-level model.
module tb_payload_aligner_stream;
  localparam int DB  = 8;
  localparam int MH  = 32;
  localparam int HLW = $clog2(MH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DB*8-1:0]  in_data = '0;
  logic [DB-1:0]    in_byte_enable = '0;
  logic             in_sop = 1'b0;
  logic             in_eop = 1'b0;
  logic [HLW-1:0]   hdr_len = '0;
  logic [MH*8-1:0]  headers;
  logic             headers_valid;
  logic             payload_valid;
  logic             payload_ready = 1'b1;
  logic [DB*8-1:0]  payload;
  logic [DB-1:0]    byte_enable;
  logic             sop;
  logic             eop;
  logic             err_short;

  payload_aligner_stream #(.DATA_BYTES(DB), .MAX_HDR_BYTES(MH), .HDR_LEN_W(HLW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_byte_enable(in_byte_enable), .in_sop(in_sop), .in_eop(in_eop), .hdr_len(hdr_len),
    .headers(headers), .headers_valid(headers_valid), .payload_valid(payload_valid),
    .payload_ready(payload_ready), .payload(payload), .byte_enable(byte_enable),
    .sop(sop), .eop(eop), .err_short(err_short)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hdr_len; int pkt_len; int ready_mode;
    int exp_beats; int exp_hv; int exp_err; int exp_low;  // exp_low < 0: not checked
  } vec_t;

  typedef struct { logic [DB*8-1:0] data; logic [DB-1:0] be; bit sop; bit eop; } beat_t;

  beat_t           exp_q[$];
  logic [MH*8-1:0] hdr_q[$];
  logic [MH*8-1:0] last_hdr = '0;
  int checks = 0, errors = 0;
  int beat_seen = 0, hv_seen = 0, err_seen = 0, low_seen = 0;
  int ready_mode = 0;  // 0: always ready, 1: toggle, 2: never ready
  bit prev_stall = 0;
  logic [DB*8+DB+2:0] prev_vec = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DB*8-1:0] be_to_mask(input logic [DB-1:0] be);
    logic [DB*8-1:0] m;
    for (int i = 0; i < DB; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Downstream ready pattern, changed just after each active edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       payload_ready = 1'b1;
        1:       payload_ready = !payload_ready;
        default: payload_ready = 1'b0;
      endcase
    end
  end

  // Monitor: samples on the falling edge, when handshakes for the next edge are settled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (!in_ready) low_seen++;
      if (prev_stall)
        check("stall_hold", 256'({payload_valid, sop, eop, byte_enable, payload}), 256'(prev_vec));
      prev_stall = payload_valid && !payload_ready;
      prev_vec   = {payload_valid, sop, eop, byte_enable, payload};
      if (payload_valid && payload_ready) begin
        beat_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got payload %h be %h with none expected", payload, byte_enable);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("pay_data", 256'(payload & be_to_mask(e.be)), 256'(e.data));
          check("pay_be", 256'(byte_enable), 256'(e.be));
          check("pay_sop", 256'(sop), 256'(e.sop));
          check("pay_eop", 256'(eop), 256'(e.eop));
        end
      end
      if (headers_valid) begin
        hv_seen++;
        if (hdr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_headers_valid: got headers %h with none expected", headers);
        end else begin
          check("headers", 256'(headers), 256'(hdr_q.pop_front()));
        end
      end
      if (err_short) err_seen++;
    end
  end

  // Model: expected header and payload beats once `sent` bytes of the packet are in.
  task automatic push_expect(input int hl, input int len, input int base, input int sent);
    int l, n, cnt;
    logic [MH*8-1:0] h;
    beat_t b;
    l = (hl > MH) ? MH : hl;
    if (sent < l) return;
    h = '0;
    for (int i = 0; i < l; i++) h[i*8 +: 8] = 8'(base + i);
    hdr_q.push_back(h);
    last_hdr = h;
    n = sent - l;
    for (int off = 0; off < n; off += DB) begin
      cnt = (n - off < DB) ? (n - off) : DB;
      if (sent != len && cnt < DB) break;
      b.data = '0;
      b.be   = '0;
      for (int i = 0; i < cnt; i++) begin
        b.data[i*8 +: 8] = 8'(base + l + off + i);
        b.be[i] = 1'b1;
      end
      b.sop = (off == 0);
      b.eop = (sent == len) && (off + DB >= n);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_beat(input logic [DB*8-1:0] d, input logic [DB-1:0] be,
                           input bit s, input bit e, input int hl);
    bit ok;
    #1;
    in_valid = 1'b1; in_data = d; in_byte_enable = be;
    in_sop = s; in_eop = e; hdr_len = HLW'(hl);
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got no acceptance in 200 cycles, required acceptance");
    end
  endtask

  task automatic go_idle();
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  // Drives the first nbeats beats (all if negative) of packet bytes base+i.
  task automatic send_pkt(input int hl, input int len, input int base, input int nbeats);
    int total, nb, l, k, cnt;
    logic [DB*8-1:0] d;
    logic [DB-1:0] be;
    total = (len + DB - 1) / DB;
    nb    = (nbeats < 0) ? total : nbeats;
    l     = (hl > MH) ? MH : hl;
    k     = (l == 0) ? 0 : (l - 1) / DB;
    for (int j = 0; j < nb; j++) begin
      cnt = (len - j * DB < DB) ? (len - j * DB) : DB;
      d = '0; be = '0;
      for (int i = 0; i < cnt; i++) begin
        d[i*8 +: 8] = 8'(base + j * DB + i);
        be[i] = 1'b1;
      end
      send_beat(d, be, j == 0, j == total - 1, hl);
      if (j == k && len >= l) begin
        #2;
        check("hv_timing", 256'(headers_valid), 256'(1));
      end
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && hdr_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d beats and %0d headers pending, required 0",
               exp_q.size(), hdr_q.size());
      exp_q.delete();
      hdr_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic clear_counts();
    beat_seen = 0; hv_seen = 0; err_seen = 0; low_seen = 0;
  endtask

  task automatic run_vector(input vec_t v, input int base);
    ready_mode = v.ready_mode;
    clear_counts();
    push_expect(v.hdr_len, v.pkt_len, base, v.pkt_len);
    send_pkt(v.hdr_len, v.pkt_len, base, -1);
    go_idle();
    drain();
    check("beat_count", 256'(beat_seen), 256'(v.exp_beats));
    check("hv_count", 256'(hv_seen), 256'(v.exp_hv));
    check("err_count", 256'(err_seen), 256'(v.exp_err));
    if (v.exp_low >= 0) check("ready_low_cycles", 256'(low_seen), 256'(v.exp_low));
    check("headers_hold", 256'(headers), 256'(last_hdr));
    ready_mode = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vecs[0] = '{20, 40, 0, 3, 1, 0, 1};   // unaligned header, overflowing eop
    vecs[1] = '{20, 12, 0, 0, 0, 1, 0};   // short packet
    vecs[2] = '{20, 40, 0, 3, 1, 0, 1};   // recovers after short packet
    vecs[3] = '{16, 32, 0, 2, 1, 0, 0};   // aligned header
    vecs[4] = '{0,  13, 0, 2, 1, 0, 0};   // zero-length header
    vecs[5] = '{16, 16, 0, 0, 1, 0, 0};   // zero-length payload
    vecs[6] = '{40, 45, 0, 2, 1, 0, 0};   // hdr_len clamped to capacity
    vecs[7] = '{3,  7,  0, 1, 1, 0, 0};   // single-beat packet
    vecs[8] = '{5,  21, 0, 2, 1, 0, 0};   // eop merges exactly into one beat
    vecs[9] = '{20, 40, 1, 3, 1, 0, -1};  // toggling backpressure

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_payload_valid", 256'(payload_valid), 256'(0));
    check("rst_headers", 256'(headers), 256'(0));
    check("rst_outputs", 256'({headers_valid, sop, eop, err_short, byte_enable, payload}), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 256'(in_ready), 256'(1));
    @(posedge clk);

    // Non-sop beat in IDLE is discarded.
    clear_counts();
    send_beat(64'hFFEE_DDCC_BBAA_9988, 8'hFF, 1'b0, 1'b1, 4);
    go_idle();
    drain();
    check("discard_beats", 256'(beat_seen), 256'(0));
    check("discard_hv", 256'(hv_seen + err_seen), 256'(0));

    for (int t = 0; t < 10; t++) run_vector(vecs[t], (t * 16) & 8'hFF);

    // New sop mid-payload abandons the old packet without eop.
    clear_counts();
    push_expect(20, 40, 8'h40, 32);
    send_pkt(20, 40, 8'h40, 4);
    push_expect(16, 32, 8'h90, 32);
    send_pkt(16, 32, 8'h90, -1);
    go_idle();
    drain();
    check("abandon_beats", 256'(beat_seen), 256'(3));
    check("abandon_hv", 256'(hv_seen), 256'(2));

    // Reset while a payload beat is stalled in PAY.
    clear_counts();
    ready_mode = 2;
    push_expect(20, 40, 8'h30, 24);
    send_pkt(20, 40, 8'h30, 4);
    go_idle();
    @(negedge clk);
    check("stalled_before_rst", 256'(payload_valid), 256'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("in_ready_during_rst", 256'(in_ready), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    ready_mode = 0;
    #1;
    check("midrst_payload_valid", 256'(payload_valid), 256'(0));
    check("midrst_headers", 256'(headers), 256'(0));
    check("midrst_outputs", 256'({headers_valid, sop, eop, err_short, byte_enable, payload}), 256'(0));
    last_hdr = '0;
    repeat (6) @(posedge clk);
    check("midrst_no_beat", 256'(beat_seen), 256'(0));
    run_vector(vecs[0], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
